// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore-style multi-cycle sequencer for the reduced RV32I core,
//                with cycle and retired-instruction counters.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        memread,
    output logic        memwrite,
    output logic        adrsrc,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        pcsrc,
    output logic        regwrite,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  aluctrl,
    output logic [2:0]  immsrc,
    output logic [1:0]  resultsrc,
    output logic [2:0]  addrmode,
    output logic        illegal,
    output logic [31:0] cycle_count,
    output logic [31:0] instret
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_TRAP     = 4'd10;

    localparam logic [6:0] c_OP_R      = 7'd51;
    localparam logic [6:0] c_OP_LOAD   = 7'd3;
    localparam logic [6:0] c_OP_IALU   = 7'd19;
    localparam logic [6:0] c_OP_STORE  = 7'd35;
    localparam logic [6:0] c_OP_BRANCH = 7'd99;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic        w_retire;
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic        w_alu_ok;
    logic [2:0]  w_alu_op;
    logic        w_br_ok;
    logic        w_br_take;
    logic        w_unused;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];
    assign w_funct7b5 = instr[30];
    assign w_unused   = ^{instr[31], instr[29:15], instr[11:7]};

    // funct7 only selects subtract for register-register operations.
    always_comb begin
        w_alu_ok = 1'b1;
        w_alu_op = 3'b000;
        case (w_funct3)
            3'b000:  w_alu_op = (r_state == c_EXECR && w_funct7b5) ? 3'b001 : 3'b000;
            3'b010:  w_alu_op = 3'b101;
            3'b110:  w_alu_op = 3'b011;
            3'b111:  w_alu_op = 3'b010;
            default: w_alu_ok = 1'b0;
        endcase
    end

    assign w_br_ok   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
    assign w_br_take = (w_funct3 == 3'b000) ? eq : ~eq;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            c_FETCH: begin
                if (mem_ready) w_next = c_DECODE;
            end
            c_DECODE: begin
                case (w_opcode)
                    c_OP_LOAD, c_OP_STORE: w_next = c_MEMADR;
                    c_OP_R:                w_next = c_EXECR;
                    c_OP_IALU:             w_next = c_EXECI;
                    c_OP_BRANCH:           w_next = c_BRANCH;
                    default:               w_next = c_TRAP;
                endcase
            end
            c_MEMADR: begin
                w_next = (w_opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
            end
            c_MEMREAD: begin
                if (mem_ready) w_next = c_MEMWB;
            end
            c_MEMWB: begin
                w_next   = c_FETCH;
                w_retire = 1'b1;
            end
            c_MEMWRITE: begin
                if (mem_ready) begin
                    w_next   = c_FETCH;
                    w_retire = 1'b1;
                end
            end
            c_EXECR, c_EXECI: begin
                w_next = w_alu_ok ? c_ALUWB : c_TRAP;
            end
            c_ALUWB: begin
                w_next   = c_FETCH;
                w_retire = 1'b1;
            end
            c_BRANCH: begin
                w_next   = w_br_ok ? c_FETCH : c_TRAP;
                w_retire = w_br_ok;
            end
            default: w_next = c_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_FETCH;
            r_cycle_count <= 32'd0;
            r_instret     <= 32'd0;
            r_illegal     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_retire) r_instret <= r_instret + 32'd1;
            if (w_next == c_TRAP) r_illegal <= 1'b1;
        end
    end

    // Moore decode of the state register; write enables are forced low while rst is high.
    always_comb begin
        memread   = 1'b0;
        memwrite  = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        pcsrc     = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluctrl   = 3'b000;
        immsrc    = 3'b111;
        resultsrc = 2'b00;
        addrmode  = 3'b000;
        case (r_state)
            c_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready & ~rst;
                pcwrite   = mem_ready & ~rst;
            end
            c_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = 3'b011;
            end
            c_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (w_opcode == c_OP_STORE) ? 3'b010 : 3'b000;
            end
            c_MEMREAD: begin
                memread  = 1'b1;
                adrsrc   = 1'b1;
                addrmode = w_funct3;
            end
            c_MEMWB: begin
                regwrite  = ~rst;
                resultsrc = 2'b01;
                addrmode  = w_funct3;
            end
            c_MEMWRITE: begin
                memwrite = ~rst;
                adrsrc   = 1'b1;
                addrmode = w_funct3;
            end
            c_EXECR: begin
                alusrca = 2'b10;
                alusrcb = 2'b00;
                aluctrl = w_alu_op;
            end
            c_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = 3'b000;
                aluctrl = w_alu_op;
            end
            c_ALUWB: begin
                regwrite  = ~rst;
                resultsrc = 2'b00;
            end
            c_BRANCH: begin
                alusrca = 2'b10;
                alusrcb = 2'b00;
                aluctrl = 3'b111;
                pcsrc   = 1'b1;
                pcwrite = w_br_ok & w_br_take & ~rst;
            end
            default: ;
        endcase
    end

    assign illegal     = r_illegal;
    assign cycle_count = r_cycle_count;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Scoreboard bench for multicycle_controller; expected output
//                vectors and counters are queued per cycle from the instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int ST_FETCH    = 0;
    localparam int ST_DECODE   = 1;
    localparam int ST_MEMADR   = 2;
    localparam int ST_MEMREAD  = 3;
    localparam int ST_MEMWB    = 4;
    localparam int ST_MEMWRITE = 5;
    localparam int ST_EXECR    = 6;
    localparam int ST_EXECI    = 7;
    localparam int ST_ALUWB    = 8;
    localparam int ST_BRANCH   = 9;
    localparam int ST_TRAP     = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;
    logic        memread, memwrite, adrsrc, irwrite, pcwrite, pcsrc, regwrite, illegal;
    logic [1:0]  alusrca, alusrcb, resultsrc;
    logic [2:0]  aluctrl, immsrc, addrmode;
    logic [31:0] cycle_count, instret;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluctrl(aluctrl), .immsrc(immsrc), .resultsrc(resultsrc),
        .addrmode(addrmode), .illegal(illegal), .cycle_count(cycle_count),
        .instret(instret)
    );

    always #5 clk = ~clk;

    logic [22:0] w_obs;
    assign w_obs = {memread, memwrite, adrsrc, irwrite, pcwrite, pcsrc, regwrite,
                    alusrca, alusrcb, aluctrl, immsrc, resultsrc, addrmode, illegal};

    typedef struct {
        logic [22:0] v;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t        scb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] tb_cyc   = 0;
    logic [31:0] tb_ret   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected output vector for a state; a = funct3/aluctrl, b = gated enable or load flag.
    function automatic logic [22:0] ev(input int st, input logic [2:0] a, input logic b);
        logic       mrd, mwr, ads, irw, pcw, pcs, rgw, ill;
        logic [1:0] sa, sbb, rs;
        logic [2:0] ac, im, am;
        {mrd, mwr, ads, irw, pcw, pcs, rgw, ill} = 8'b0;
        sa = 2'b00; sbb = 2'b00; rs = 2'b00;
        ac = 3'b000; im = 3'b111; am = 3'b000;
        case (st)
            ST_FETCH:    begin mrd = 1; sbb = 2'b10; rs = 2'b10; irw = b; pcw = b; end
            ST_DECODE:   begin sa = 2'b01; sbb = 2'b01; im = 3'b011; end
            ST_MEMADR:   begin sa = 2'b10; sbb = 2'b01; im = b ? 3'b000 : 3'b010; end
            ST_MEMREAD:  begin mrd = 1; ads = 1; am = a; end
            ST_MEMWB:    begin rgw = 1; rs = 2'b01; am = a; end
            ST_MEMWRITE: begin mwr = 1; ads = 1; am = a; end
            ST_EXECR:    begin sa = 2'b10; sbb = 2'b00; ac = a; end
            ST_EXECI:    begin sa = 2'b10; sbb = 2'b01; im = 3'b000; ac = a; end
            ST_ALUWB:    begin rgw = 1; rs = 2'b00; end
            ST_BRANCH:   begin sa = 2'b10; sbb = 2'b00; ac = 3'b111; pcs = 1; pcw = b; end
            default:     ill = 1;
        endcase
        return {mrd, mwr, ads, irw, pcw, pcs, rgw, sa, sbb, ac, im, rs, am, ill};
    endfunction

    function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic cyc(input logic mr, input logic eqv, input logic [22:0] v, input string tag);
        exp_t e;
        mem_ready = mr;
        eq        = eqv;
        e.v   = v;
        e.cyc = tb_cyc;
        e.ret = tb_ret;
        scb.push_back(e);
        @(negedge clk);
        e = scb.pop_front();
        check({tag, " outputs"}, {9'b0, w_obs}, {9'b0, e.v});
        check({tag, " cycle_count"}, cycle_count, e.cyc);
        check({tag, " instret"}, instret, e.ret);
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("reset write enables", {28'b0, irwrite, pcwrite, regwrite, memwrite}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tb_cyc = 0;
        tb_ret = 0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic eqv, input int fwait, input int mwait);
        logic [6:0] op;
        logic [2:0] f3;
        op    = ins[6:0];
        f3    = ins[14:12];
        instr = ins;
        repeat (fwait) cyc(1'b0, eqv, ev(ST_FETCH, 3'b0, 1'b0), "fetch-wait");
        cyc(1'b1, eqv, ev(ST_FETCH, 3'b0, 1'b1), "fetch");
        cyc(rbit(), eqv, ev(ST_DECODE, 3'b0, 1'b0), "decode");
        case (op)
            7'd3: begin
                cyc(rbit(), eqv, ev(ST_MEMADR, 3'b0, 1'b1), "memadr-ld");
                repeat (mwait) cyc(1'b0, eqv, ev(ST_MEMREAD, f3, 1'b0), "memread-wait");
                cyc(1'b1, eqv, ev(ST_MEMREAD, f3, 1'b0), "memread");
                cyc(rbit(), eqv, ev(ST_MEMWB, f3, 1'b0), "memwb");
                tb_ret++;
            end
            7'd35: begin
                cyc(rbit(), eqv, ev(ST_MEMADR, 3'b0, 1'b0), "memadr-st");
                repeat (mwait) cyc(1'b0, eqv, ev(ST_MEMWRITE, f3, 1'b0), "memwrite-wait");
                cyc(1'b1, eqv, ev(ST_MEMWRITE, f3, 1'b0), "memwrite");
                tb_ret++;
            end
            7'd51, 7'd19: begin
                if (op == 7'd51)
                    cyc(rbit(), eqv, ev(ST_EXECR, alu_exp(f3, ins[30]), 1'b0), "execr");
                else
                    cyc(rbit(), eqv, ev(ST_EXECI, alu_exp(f3, 1'b0), 1'b0), "execi");
                if (f3_ok(f3)) begin
                    cyc(rbit(), eqv, ev(ST_ALUWB, 3'b0, 1'b0), "aluwb");
                    tb_ret++;
                end
            end
            7'd99: begin
                cyc(rbit(), eqv, ev(ST_BRANCH, 3'b0, (f3 == 3'b000) ? eqv : ~eqv), "branch");
                tb_ret++;
            end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1; instr = 32'd0; eq = 1'b0; mem_ready = 1'b0;
        do_reset();

        run_instr(32'h002081B3, 1'b0, 0, 0);   // add
        run_instr(32'h402081B3, 1'b0, 0, 0);   // sub
        run_instr(32'h0050A193, 1'b1, 0, 0);   // slti
        run_instr(32'h0020F1B3, 1'b0, 1, 0);   // and
        run_instr(32'h0020E1B3, 1'b0, 0, 0);   // or
        run_instr(32'h0050E193, 1'b0, 0, 0);   // ori
        run_instr(32'h0050F193, 1'b0, 0, 0);   // andi
        run_instr(32'h40008193, 1'b0, 0, 0);   // addi, imm bit 30 set
        run_instr(32'h0000A183, 1'b0, 0, 3);   // lw, 3 memory stalls
        run_instr(32'h00008183, 1'b0, 2, 1);   // lb
        run_instr(32'h0020A023, 1'b0, 0, 2);   // sw
        run_instr(32'h00208023, 1'b0, 1, 0);   // sb
        run_instr(32'h00208063, 1'b1, 0, 0);   // beq taken
        run_instr(32'h00209063, 1'b1, 0, 0);   // bne not taken
        run_instr(32'h00209063, 1'b0, 0, 0);   // bne taken
        run_instr(32'h00208063, 1'b0, 0, 0);   // beq not taken

        // Unsupported opcode parks the sequencer in TRAP until reset.
        run_instr(32'h0000006F, 1'b0, 0, 0);
        repeat (20) cyc(rbit(), rbit(), ev(ST_TRAP, 3'b0, 1'b0), "trap");
        do_reset();
        run_instr(32'h002081B3, 1'b0, 0, 0);

        // Reset in the middle of a store wait abandons the store.
        instr = 32'h0020A023;
        cyc(1'b1, 1'b0, ev(ST_FETCH, 3'b0, 1'b1), "abort fetch");
        cyc(1'b0, 1'b0, ev(ST_DECODE, 3'b0, 1'b0), "abort decode");
        cyc(1'b0, 1'b0, ev(ST_MEMADR, 3'b0, 1'b0), "abort memadr");
        repeat (2) cyc(1'b0, 1'b0, ev(ST_MEMWRITE, 3'b010, 1'b0), "abort memwrite");
        do_reset();
        run_instr(32'h002081B3, 1'b0, 0, 0);

        // Unsupported R-type funct3 traps after EXECR.
        run_instr(32'h002091B3, 1'b0, 0, 0);
        repeat (3) cyc(rbit(), rbit(), ev(ST_TRAP, 3'b0, 1'b0), "trap-funct3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
